// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_if
//  Description : Fetch/regfile/writeback/execute bundle around decode_stage.
//                The slave view belongs to the decode stage; the master view
//                belongs to whatever drives it (fetch, regfile, execute).
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // fetch -> decode handshake
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_instr;
    logic [DATA_WIDTH-1:0] i_pc;
    logic                  i_flush;

    // register file read ports
    logic [ADDR_WIDTH-1:0] o_rd_addr_1;
    logic [ADDR_WIDTH-1:0] o_rd_addr_2;
    logic [DATA_WIDTH-1:0] i_rd_data_1;
    logic [DATA_WIDTH-1:0] i_rd_data_2;

    // writeback bypass
    logic                  i_wb_we;
    logic [ADDR_WIDTH-1:0] i_wb_addr;
    logic [DATA_WIDTH-1:0] i_wb_data;

    // decode -> execute
    logic                  i_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_pc;
    logic [DATA_WIDTH-1:0] o_rs1_data;
    logic [DATA_WIDTH-1:0] o_rs2_data;
    logic [DATA_WIDTH-1:0] o_imm;
    logic [ADDR_WIDTH-1:0] o_rs1;
    logic [ADDR_WIDTH-1:0] o_rs2;
    logic [ADDR_WIDTH-1:0] o_rd;
    logic [3:0]            o_alu_op;
    logic [2:0]            o_funct3;
    logic                  o_reg_we;
    logic                  o_mem_re;
    logic                  o_mem_we;
    logic                  o_branch;
    logic                  o_jal;
    logic                  o_jalr;
    logic                  o_lui;
    logic                  o_auipc;
    logic                  o_alu_src_imm;
    logic                  o_illegal;

    modport master (
        output i_valid, i_instr, i_pc, i_flush,
        output i_rd_data_1, i_rd_data_2,
        output i_wb_we, i_wb_addr, i_wb_data,
        output i_ready,
        input  o_ready, o_rd_addr_1, o_rd_addr_2,
        input  o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm,
        input  o_rs1, o_rs2, o_rd, o_alu_op, o_funct3,
        input  o_reg_we, o_mem_re, o_mem_we, o_branch, o_jal, o_jalr,
        input  o_lui, o_auipc, o_alu_src_imm, o_illegal
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_flush,
        input  i_rd_data_1, i_rd_data_2,
        input  i_wb_we, i_wb_addr, i_wb_data,
        input  i_ready,
        output o_ready, o_rd_addr_1, o_rd_addr_2,
        output o_valid, o_pc, o_rs1_data, o_rs2_data, o_imm,
        output o_rs1, o_rs2, o_rd, o_alu_op, o_funct3,
        output o_reg_we, o_mem_re, o_mem_we, o_branch, o_jal, o_jalr,
        output o_lui, o_auipc, o_alu_src_imm, o_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : RV32I-style decode stage with a single output register
//                (EMPTY/FULL), register-file read with writeback bypass,
//                immediate generation and control decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,      // synchronous, active low
    decode_stage_if.slave    bus
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_capture;

    // instruction fields
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [ADDR_WIDTH-1:0] w_rs1;
    logic [ADDR_WIDTH-1:0] w_rs2;
    logic [ADDR_WIDTH-1:0] w_rd;
    logic                  w_sign;

    // decoded values
    logic [DATA_WIDTH-1:0] w_imm;
    logic [3:0]            w_alu_op;
    logic                  w_reg_we;
    logic                  w_mem_re;
    logic                  w_mem_we;
    logic                  w_branch;
    logic                  w_jal;
    logic                  w_jalr;
    logic                  w_lui;
    logic                  w_auipc;
    logic                  w_alu_src_imm;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;

    // output register
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [ADDR_WIDTH-1:0] r_rs1;
    logic [ADDR_WIDTH-1:0] r_rs2;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [3:0]            r_alu_op;
    logic [2:0]            r_funct3;
    logic                  r_reg_we;
    logic                  r_mem_re;
    logic                  r_mem_we;
    logic                  r_branch;
    logic                  r_jal;
    logic                  r_jalr;
    logic                  r_lui;
    logic                  r_auipc;
    logic                  r_alu_src_imm;
    logic                  r_illegal;

    assign w_opcode = bus.i_instr[6:0];
    assign w_funct3 = bus.i_instr[14:12];
    assign w_rs1    = bus.i_instr[19:15];
    assign w_rs2    = bus.i_instr[24:20];
    assign w_rd     = bus.i_instr[11:7];
    assign w_sign   = bus.i_instr[31];

    // Register-file addresses come straight from the presented instruction
    // so the combinational read data is ready by the capture edge.
    assign bus.o_rd_addr_1 = w_rs1;
    assign bus.o_rd_addr_2 = w_rs2;

    // No skid buffer: accept only when the output slot is free or draining.
    assign bus.o_ready = (r_state == S_EMPTY) || bus.i_ready;
    assign w_capture   = bus.i_valid && bus.o_ready && !bus.i_flush;

    // Output slot occupancy register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next state: flush wins, then capture, then drain.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_capture) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.i_flush) begin
                    w_state_next = S_EMPTY;
                end else if (w_capture) begin
                    w_state_next = S_FULL;
                end else if (bus.i_ready) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Opcode decode, immediate selection and control flags.
    always_comb begin
        w_imm         = '0;
        w_alu_op      = 4'b0000;
        w_reg_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_we      = 1'b0;
        w_branch      = 1'b0;
        w_jal         = 1'b0;
        w_jalr        = 1'b0;
        w_lui         = 1'b0;
        w_auipc       = 1'b0;
        w_alu_src_imm = 1'b0;
        w_illegal     = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_alu_op = {bus.i_instr[30], w_funct3};
                w_reg_we = 1'b1;
            end
            c_OP_IALU: begin
                // bit 30 only distinguishes SRAI from SRLI
                w_alu_op      = {(w_funct3 == 3'b101) ? bus.i_instr[30] : 1'b0, w_funct3};
                w_imm         = {{(DATA_WIDTH-12){w_sign}}, bus.i_instr[31:20]};
                w_reg_we      = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_LOAD: begin
                w_imm         = {{(DATA_WIDTH-12){w_sign}}, bus.i_instr[31:20]};
                w_reg_we      = 1'b1;
                w_mem_re      = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_STORE: begin
                w_imm         = {{(DATA_WIDTH-12){w_sign}}, bus.i_instr[31:25], bus.i_instr[11:7]};
                w_mem_we      = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_BRANCH: begin
                w_imm    = {{(DATA_WIDTH-13){w_sign}}, bus.i_instr[31], bus.i_instr[7],
                            bus.i_instr[30:25], bus.i_instr[11:8], 1'b0};
                w_branch = 1'b1;
            end
            c_OP_JAL: begin
                w_imm         = {{(DATA_WIDTH-21){w_sign}}, bus.i_instr[31], bus.i_instr[19:12],
                                 bus.i_instr[20], bus.i_instr[30:21], 1'b0};
                w_reg_we      = 1'b1;
                w_jal         = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_JALR: begin
                w_imm         = {{(DATA_WIDTH-12){w_sign}}, bus.i_instr[31:20]};
                w_reg_we      = 1'b1;
                w_jalr        = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_LUI: begin
                w_imm         = {{(DATA_WIDTH-32){w_sign}}, bus.i_instr[31:12], 12'b0};
                w_reg_we      = 1'b1;
                w_lui         = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            c_OP_AUIPC: begin
                w_imm         = {{(DATA_WIDTH-32){w_sign}}, bus.i_instr[31:12], 12'b0};
                w_reg_we      = 1'b1;
                w_auipc       = 1'b1;
                w_alu_src_imm = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // x0 is never a real destination
        if (w_rd == '0) begin
            w_reg_we = 1'b0;
        end
    end

    // Source operands: x0 reads zero, otherwise the in-flight writeback wins.
    always_comb begin
        w_rs1_data = bus.i_rd_data_1;
        w_rs2_data = bus.i_rd_data_2;
        if (w_rs1 == '0) begin
            w_rs1_data = '0;
        end else if (bus.i_wb_we && (bus.i_wb_addr == w_rs1)) begin
            w_rs1_data = bus.i_wb_data;
        end
        if (w_rs2 == '0) begin
            w_rs2_data = '0;
        end else if (bus.i_wb_we && (bus.i_wb_addr == w_rs2)) begin
            w_rs2_data = bus.i_wb_data;
        end
    end

    // Output register payload: loads on capture, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_alu_op      <= '0;
            r_funct3      <= '0;
            r_reg_we      <= 1'b0;
            r_mem_re      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_branch      <= 1'b0;
            r_jal         <= 1'b0;
            r_jalr        <= 1'b0;
            r_lui         <= 1'b0;
            r_auipc       <= 1'b0;
            r_alu_src_imm <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (w_capture) begin
            r_pc          <= bus.i_pc;
            r_rs1_data    <= w_rs1_data;
            r_rs2_data    <= w_rs2_data;
            r_imm         <= w_imm;
            r_rs1         <= w_rs1;
            r_rs2         <= w_rs2;
            r_rd          <= w_rd;
            r_alu_op      <= w_alu_op;
            r_funct3      <= w_funct3;
            r_reg_we      <= w_reg_we;
            r_mem_re      <= w_mem_re;
            r_mem_we      <= w_mem_we;
            r_branch      <= w_branch;
            r_jal         <= w_jal;
            r_jalr        <= w_jalr;
            r_lui         <= w_lui;
            r_auipc       <= w_auipc;
            r_alu_src_imm <= w_alu_src_imm;
            r_illegal     <= w_illegal;
        end
    end

    assign bus.o_valid       = (r_state == S_FULL);
    assign bus.o_pc          = r_pc;
    assign bus.o_rs1_data    = r_rs1_data;
    assign bus.o_rs2_data    = r_rs2_data;
    assign bus.o_imm         = r_imm;
    assign bus.o_rs1         = r_rs1;
    assign bus.o_rs2         = r_rs2;
    assign bus.o_rd          = r_rd;
    assign bus.o_alu_op      = r_alu_op;
    assign bus.o_funct3      = r_funct3;
    assign bus.o_reg_we      = r_reg_we;
    assign bus.o_mem_re      = r_mem_re;
    assign bus.o_mem_we      = r_mem_we;
    assign bus.o_branch      = r_branch;
    assign bus.o_jal         = r_jal;
    assign bus.o_jalr        = r_jalr;
    assign bus.o_lui         = r_lui;
    assign bus.o_auipc       = r_auipc;
    assign bus.o_alu_src_imm = r_alu_src_imm;
    assign bus.o_illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Self-checking bench for decode_stage: directed cases with
//                literal expectations followed by randomized traffic compared
//                every cycle against an instruction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        src_imm;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;
    exp_t m = '0;

    decode_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: what an instruction means, straight from the ISA rules.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] rd1, input logic [31:0] rd2,
                                          input logic wbwe, input logic [4:0] wba,
                                          input logic [31:0] wbd);
        exp_t e;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        e       = '0;
        e.valid = 1'b1;
        e.pc    = pc;
        e.rs1   = ins[19:15];
        e.rs2   = ins[24:20];
        e.rd    = ins[11:7];
        e.f3    = ins[14:12];
        imm_i   = 32'($signed(ins[31:20]));
        imm_s   = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b   = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_u   = {ins[31:12], 12'h000};
        imm_j   = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        case (ins[6:0])
            7'h33: begin e.reg_we = 1; e.alu = {ins[30], ins[14:12]}; end
            7'h13: begin e.reg_we = 1; e.imm = imm_i; e.src_imm = 1;
                         e.alu = {(ins[14:12] == 3'd5) & ins[30], ins[14:12]}; end
            7'h03: begin e.reg_we = 1; e.mem_re = 1; e.imm = imm_i; e.src_imm = 1; end
            7'h23: begin e.mem_we = 1; e.imm = imm_s; e.src_imm = 1; end
            7'h63: begin e.br = 1; e.imm = imm_b; end
            7'h6F: begin e.reg_we = 1; e.jal = 1; e.imm = imm_j; e.src_imm = 1; end
            7'h67: begin e.reg_we = 1; e.jalr = 1; e.imm = imm_i; e.src_imm = 1; end
            7'h37: begin e.reg_we = 1; e.lui = 1; e.imm = imm_u; e.src_imm = 1; end
            7'h17: begin e.reg_we = 1; e.auipc = 1; e.imm = imm_u; e.src_imm = 1; end
            default: e.ill = 1;
        endcase
        if (e.rd == 5'd0) e.reg_we = 0;
        e.rs1d = (e.rs1 == 0) ? 32'd0 : ((wbwe && wba == e.rs1) ? wbd : rd1);
        e.rs2d = (e.rs2 == 0) ? 32'd0 : ((wbwe && wba == e.rs2) ? wbd : rd2);
        return e;
    endfunction

    // Model of the output slot, advanced on each rising edge.
    always @(posedge clk) begin
        if (!rst) begin
            m = '0;
        end else if (bus.i_flush) begin
            m.valid = 1'b0;
        end else if (bus.i_valid && (!m.valid || bus.i_ready)) begin
            m = model_decode(bus.i_instr, bus.i_pc, bus.i_rd_data_1, bus.i_rd_data_2,
                             bus.i_wb_we, bus.i_wb_addr, bus.i_wb_data);
        end else if (bus.i_ready) begin
            m.valid = 1'b0;
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        exp_t d;
        if (chk_en) begin
            d = '{bus.o_valid, bus.o_pc, bus.o_rs1_data, bus.o_rs2_data, bus.o_imm,
                  bus.o_rs1, bus.o_rs2, bus.o_rd, bus.o_alu_op, bus.o_funct3,
                  bus.o_reg_we, bus.o_mem_re, bus.o_mem_we, bus.o_branch, bus.o_jal,
                  bus.o_jalr, bus.o_lui, bus.o_auipc, bus.o_alu_src_imm, bus.o_illegal};
            total++;
            if (d !== m) begin
                bad++;
                $display("FAIL outregs t=%0t got %h expected %h", $time, d, m);
            end
            total++;
            if (bus.o_ready !== (!m.valid || bus.i_ready)) begin
                bad++;
                $display("FAIL o_ready t=%0t got %b expected %b", $time, bus.o_ready,
                         (!m.valid || bus.i_ready));
            end
            total++;
            if (bus.o_rd_addr_1 !== bus.i_instr[19:15] || bus.o_rd_addr_2 !== bus.i_instr[24:20]) begin
                bad++;
                $display("FAIL rd_addr t=%0t got %h/%h expected %h/%h", $time, bus.o_rd_addr_1,
                         bus.o_rd_addr_2, bus.i_instr[19:15], bus.i_instr[24:20]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t pin;
        logic [6:0]  ops [9];
        logic [31:0] ins;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        bus.i_valid = 0; bus.i_instr = 0; bus.i_pc = 0; bus.i_flush = 0;
        bus.i_rd_data_1 = 0; bus.i_rd_data_2 = 0;
        bus.i_wb_we = 0; bus.i_wb_addr = 0; bus.i_wb_data = 0; bus.i_ready = 1;

        // model pins
        pin = model_decode(32'hFFF08293, 32'h0, 32'h10, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("model_addi_imm", pin.imm, 32'hFFFFFFFF);
        pin = model_decode(32'hFE208EE3, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("model_beq_imm", pin.imm, 32'hFFFFFFFC);

        // reset
        rst = 0;
        step(); step();
        chk_en = 1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_imm", bus.o_imm, 32'd0);
        chk("rst_reg_we", 32'(bus.o_reg_we), 32'd0);
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        rst = 1;

        // ADDI x5,x1,-1
        bus.i_valid = 1; bus.i_instr = 32'hFFF08293; bus.i_pc = 32'h100; bus.i_rd_data_1 = 32'h10;
        #1 chk("addi_rd_addr_1", 32'(bus.o_rd_addr_1), 32'd1);
        step();
        chk("addi_valid", 32'(bus.o_valid), 32'd1);
        chk("addi_imm", bus.o_imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(bus.o_rd), 32'd5);
        chk("addi_rs1_data", bus.o_rs1_data, 32'h10);
        chk("addi_reg_we", 32'(bus.o_reg_we), 32'd1);
        chk("addi_alu_op", 32'(bus.o_alu_op), 32'd0);

        // bypass, then x0 source
        bus.i_wb_we = 1; bus.i_wb_addr = 1; bus.i_wb_data = 32'hDEADBEEF;
        step();
        chk("bypass_rs1", bus.o_rs1_data, 32'hDEADBEEF);
        bus.i_instr = 32'hFFF00293; bus.i_wb_addr = 0; bus.i_rd_data_1 = 32'h55;
        step();
        chk("x0_rs1", bus.o_rs1_data, 32'd0);

        // backpressure with ADD x3,x1,x2 waiting
        bus.i_wb_we = 0; bus.i_ready = 0; bus.i_instr = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", 32'(bus.o_ready), 32'd0);
            step();
            chk("bp_hold_rd", 32'(bus.o_rd), 32'd5);
            chk("bp_hold_valid", 32'(bus.o_valid), 32'd1);
        end
        bus.i_ready = 1;
        #1 chk("bp_release_ready", 32'(bus.o_ready), 32'd1);
        step();
        chk("bp_new_rd", 32'(bus.o_rd), 32'd3);
        chk("bp_new_src_imm", 32'(bus.o_alu_src_imm), 32'd0);

        // flush of a presented instruction, then flush while stalled
        bus.i_flush = 1;
        step();
        chk("flush_valid", 32'(bus.o_valid), 32'd0);
        bus.i_flush = 0;
        step();
        bus.i_ready = 0; bus.i_flush = 1;
        step();
        chk("flush_full_valid", 32'(bus.o_valid), 32'd0);
        bus.i_flush = 0; bus.i_ready = 1;

        // illegal and branch
        bus.i_instr = 32'h00000000;
        step();
        chk("ill_flag", 32'(bus.o_illegal), 32'd1);
        chk("ill_reg_we", 32'(bus.o_reg_we), 32'd0);
        bus.i_instr = 32'hFE208EE3;
        step();
        chk("beq_branch", 32'(bus.o_branch), 32'd1);
        chk("beq_imm", bus.o_imm, 32'hFFFFFFFC);
        chk("beq_reg_we", 32'(bus.o_reg_we), 32'd0);

        // reset while full
        bus.i_instr = 32'hFFF08293;
        step();
        rst = 0;
        step();
        chk("midrst_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_imm", bus.o_imm, 32'd0);
        rst = 1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sel = int'($urandom_range(0, 9));
            ins = $urandom;
            if (sel < 9) ins[6:0] = ops[sel];
            if ($urandom_range(0, 7) == 0) ins[19:15] = 5'd0;
            if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
            bus.i_instr     = ins;
            bus.i_pc        = $urandom;
            bus.i_valid     = ($urandom_range(0, 3) != 0);
            bus.i_ready     = ($urandom_range(0, 2) != 0);
            bus.i_flush     = ($urandom_range(0, 15) == 0);
            bus.i_rd_data_1 = $urandom;
            bus.i_rd_data_2 = $urandom;
            bus.i_wb_we     = $urandom_range(0, 1) == 1;
            bus.i_wb_data   = $urandom;
            case ($urandom_range(0, 3))
                0, 1: bus.i_wb_addr = ins[19:15];
                2:    bus.i_wb_addr = ins[24:20];
                default: bus.i_wb_addr = 5'($urandom);
            endcase
            rst = ($urandom_range(0, 99) != 0);
            step();
        end
        rst = 1; bus.i_valid = 0; bus.i_ready = 1; bus.i_flush = 0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
